// File: rtl/modport_counter_pkg.sv
// Shared types and next-state rule for the counter subsystem.
// The same rule is available to the datapath and to anything that needs a reference.
package counter_pkg;

    localparam int COUNT_W = 4;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Load wins over direction; arithmetic wraps silently modulo 2^COUNT_W.
    function automatic count_t next_count(count_t cur, logic load, count_t din, dir_e dir);
        count_t result;
        if (load) begin
            result = din;
        end else if (dir == DIR_UP) begin
            result = cur + count_t'(1);
        end else begin
            result = cur - count_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/modport_counter_if.sv
// Counter interface: the driver side supplies load data and direction,
// the counter side returns the registered count.
interface modport_counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d_in;
    logic             load;
    logic             up_dn;
    logic [WIDTH-1:0] count;

    modport master (
        output d_in,
        output load,
        output up_dn,
        input  count
    );

    modport slave (
        input  d_in,
        input  load,
        input  up_dn,
        output count
    );

endinterface

// File: rtl/modport_counter_next.sv
// Purely combinational next-count computation: load mux plus incrementer/decrementer.
// Reset is not handled here; the register in the top owns it.
import counter_pkg::*;

module modport_counter_next #(
    parameter int WIDTH = COUNT_W
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (WIDTH == COUNT_W) begin : g_pkg_width
            // At the package width, reuse the shared rule so both sides agree by construction.
            always_comb begin
                nxt = next_count(count_t'(cur), load, count_t'(din), dir_e'(up_dn));
            end
        end else begin : g_any_width
            always_comb begin
                nxt = cur;
                if (load) begin
                    nxt = din;
                end else if (up_dn) begin
                    nxt = cur + WIDTH'(1);
                end else begin
                    nxt = cur - WIDTH'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/modport_counter.sv
// Loadable up/down counter datapath: holds the count register and reset,
// with the next value computed by modport_counter_next.
import counter_pkg::*;

module modport_counter #(
    parameter int WIDTH = COUNT_W
) (
    input  logic                clk,
    input  logic                rst,
    modport_counter_if.slave    bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    modport_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur   (count_q),
        .load  (bus.load),
        .din   (bus.d_in),
        .up_dn (bus.up_dn),
        .nxt   (count_d)
    );

    // No enable: the register updates every edge; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;

endmodule

// File: tb/tb_modport_counter.sv
// Self-checking bench for modport_counter: directed plan followed by random cycles,
// compared against a plain modulo-16 arithmetic model.
module tb_modport_counter;

    localparam int W   = 4;
    localparam int MOD = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_count;

    modport_counter_if #(.WIDTH(W)) bus ();

    modport_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs (called 1 unit after an edge), take one edge, then check 1 unit later.
    task automatic do_cycle(input string tag, input logic r, input logic l,
                            input logic u, input int d, input int expect_val);
        logic [W-1:0] exp_bits;
        rst       = r;
        bus.load  = l;
        bus.up_dn = u;
        bus.d_in  = W'(d);
        @(posedge clk);
        if (r)      exp_count = 0;
        else if (l) exp_count = d % MOD;
        else if (u) exp_count = (exp_count + 1) % MOD;
        else        exp_count = (exp_count + MOD - 1) % MOD;
        #1;
        exp_bits = W'(exp_count);
        checks++;
        assert (bus.count === exp_bits) else begin
            errors++;
            $error("FAIL %s: count=%0d expected %0d", tag, bus.count, exp_bits);
        end
        // Directed steps also carry a hand-derived value; check the model against it.
        if (expect_val >= 0) begin
            checks++;
            assert (bus.count === W'(expect_val)) else begin
                errors++;
                $error("FAIL %s_plan: count=%0d expected %0d", tag, bus.count, expect_val);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 0;
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.up_dn = 1'b0;
        bus.d_in  = '0;

        // Reset beats load
        do_cycle("reset0", 1'b1, 1'b1, 1'b1, 9, 0);
        do_cycle("reset1", 1'b1, 1'b1, 1'b1, 9, 0);

        // Load then count up
        do_cycle("load5",  1'b0, 1'b1, 1'b0, 5, 5);
        do_cycle("up6",    1'b0, 1'b0, 1'b1, 0, 6);
        do_cycle("up7",    1'b0, 1'b0, 1'b1, 0, 7);
        do_cycle("up8",    1'b0, 1'b0, 1'b1, 0, 8);

        // Up wrap
        do_cycle("load14", 1'b0, 1'b1, 1'b1, 14, 14);
        do_cycle("up15",   1'b0, 1'b0, 1'b1, 0, 15);
        do_cycle("wrap0",  1'b0, 1'b0, 1'b1, 0, 0);
        do_cycle("up1",    1'b0, 1'b0, 1'b1, 0, 1);

        // Down wrap
        do_cycle("load1",  1'b0, 1'b1, 1'b0, 1, 1);
        do_cycle("dn0",    1'b0, 1'b0, 1'b0, 0, 0);
        do_cycle("wrap15", 1'b0, 1'b0, 1'b0, 0, 15);
        do_cycle("dn14",   1'b0, 1'b0, 1'b0, 0, 14);

        // Load priority over direction, including reloading the current value
        do_cycle("ldpri0", 1'b0, 1'b1, 1'b0, 3, 3);
        do_cycle("ldpri1", 1'b0, 1'b1, 1'b0, 3, 3);
        do_cycle("after",  1'b0, 1'b0, 1'b1, 0, 4);

        // Reset mid-count
        do_cycle("load10", 1'b0, 1'b1, 1'b1, 10, 10);
        do_cycle("midrst", 1'b1, 1'b0, 1'b1, 0, 0);
        do_cycle("res1",   1'b0, 1'b0, 1'b1, 0, 1);
        do_cycle("res2",   1'b0, 1'b0, 1'b1, 0, 2);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic r, l, u;
            int   d;
            r = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 3) == 0);
            u = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, MOD - 1));
            do_cycle("rand", r, l, u, d, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
